// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the pipelined processor.
//
// Sits behind the EX/MEM pipeline register. Issues loads and stores to the
// data memory over a req/ack handshake. Stalls the front of the pipeline
// while the memory is busy. Resolves branches and drives the MEM/WB
// pipeline register.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   ex_mem_*                     registered EX/MEM control and data
//   dmem_req/we/addr/wdata       request side of the data-memory handshake
//   dmem_ack/rdata               completion and load data from the memory
//   mem_stall                    hold PC, IF/ID, ID/EX and EX/MEM
//   mem_fault                    sticky access-timeout flag
//   pc_src, branch_target        branch resolution
//   mem_wb_*                     MEM/WB pipeline register outputs
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_MemtoReg,
    input  logic        ex_mem_MemRead,
    input  logic        ex_mem_MemWrite,
    input  logic        ex_mem_Branch,
    input  logic        ex_mem_RegWrite,
    input  logic [31:0] ex_mem_pc,
    input  logic        ex_mem_zero,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_writedata,
    input  logic [4:0]  ex_mem_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        mem_wb_RegWrite,
    output logic        mem_wb_MemtoReg,
    output logic [31:0] mem_wb_read_data,
    output logic [31:0] mem_wb_alu_result,
    output logic [4:0]  mem_wb_rd
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;

    logic access;
    logic is_read;
    logic req_raw;
    logic abort;
    logic stall_raw;

    // A combined read+write is treated as a write; its load data is dropped.
    assign access  = ex_mem_MemRead | ex_mem_MemWrite;
    assign is_read = ex_mem_MemRead & ~ex_mem_MemWrite;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        req_raw      = 1'b0;
        abort        = 1'b0;
        case (state)
            S_IDLE: begin
                req_raw = access;
                if (access && !dmem_ack) begin
                    state_nxt    = S_WAIT;
                    wait_cnt_nxt = CNT_W'(1);
                end
            end
            S_WAIT: begin
                // EX/MEM is frozen by mem_stall, so the request is still present.
                req_raw = 1'b1;
                if (dmem_ack) begin
                    state_nxt    = S_IDLE;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == CNT_MAX) begin
                    abort        = 1'b1;
                    state_nxt    = S_IDLE;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = S_IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Covers the IDLE request cycle and every WAIT cycle except the one
    // that completes or aborts.
    assign stall_raw = access & ~dmem_ack & ~abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_fault <= 1'b0;
        end else if (abort) begin
            mem_fault <= 1'b1;
        end
    end

    // MEM/WB register: bubble while stalled, kill the write on abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_RegWrite   <= 1'b0;
            mem_wb_MemtoReg   <= 1'b0;
            mem_wb_read_data  <= '0;
            mem_wb_alu_result <= '0;
            mem_wb_rd         <= '0;
        end else if (abort) begin
            mem_wb_RegWrite   <= 1'b0;
            mem_wb_MemtoReg   <= ex_mem_MemtoReg;
            mem_wb_read_data  <= '0;
            mem_wb_alu_result <= ex_mem_alu_result;
            mem_wb_rd         <= ex_mem_rd;
        end else if (stall_raw) begin
            mem_wb_RegWrite   <= 1'b0;
            mem_wb_MemtoReg   <= 1'b0;
        end else begin
            mem_wb_RegWrite   <= ex_mem_RegWrite & (ex_mem_rd != 5'd0);
            mem_wb_MemtoReg   <= ex_mem_MemtoReg;
            mem_wb_read_data  <= is_read ? dmem_rdata : 32'd0;
            mem_wb_alu_result <= ex_mem_alu_result;
            mem_wb_rd         <= ex_mem_rd;
        end
    end

    // Reset gates every combinational output so a mid-WAIT reset drops the
    // request immediately rather than at the next edge.
    assign dmem_req      = req_raw & ~rst;
    assign dmem_we       = ex_mem_MemWrite & ~rst;
    assign dmem_addr     = rst ? 32'd0 : ex_mem_alu_result;
    assign dmem_wdata    = rst ? 32'd0 : ex_mem_writedata;
    assign mem_stall     = stall_raw & ~rst;
    assign pc_src        = ex_mem_Branch & ex_mem_zero & ~rst;
    assign branch_target = rst ? 32'd0 : ex_mem_pc;

endmodule
